vblank_arbiter: RTL and testbench
=================================

VBLANK_ARBITER -- requirements
Module: vblank_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the video RAM port (index 0 = main, 1 = pacman, 2 = ghosts).
REQ-002 Parameter QUOTA, default 144, maximum consecutive granted cycles per grant tenure.
REQ-003 Parameter VBLANK_LINE, default 480, first vertical line of the access window.
REQ-004 Parameter VTOTAL, default 525, lines per frame; the window is VBLANK_LINE..VTOTAL-1 inclusive.
REQ-005 Port list: clk  in  1  system clock; single clock domain, all logic on posedge clk.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 shpos  in  10  current horizontal pixel position; used for observability only, not used for arbitration.
REQ-008 svpos  in  10  current vertical line.
REQ-009 req  in  NREQ  per-requester access request, level.
REQ-010 grant  out  NREQ  one-hot or zero registered grant.
REQ-011 owner  out  2  index of the current or last granted requester.
REQ-012 window  out  1  registered flag, high while the access window is open.
REQ-013 quota_left  out  8  remaining granted cycles in the current tenure.

Function
REQ-014 The window flag SHALL be registered as (VBLANK_LINE <= svpos < VTOTAL) and SHALL lag svpos by one cycle.
REQ-015 FSM states: IDLE, GRANT, HANDOVER.
- IDLE -> GRANT: window high and any req bit high.
- GRANT -> HANDOVER: the owner's req drops, quota_left reaches 1 while granted, or window goes low.
- HANDOVER -> IDLE: unconditional after exactly one dead cycle with grant zero.
REQ-016 Selection in IDLE SHALL be round-robin, searching from (last owner + 1) mod NREQ; the first req bit found wins.
REQ-017 grant SHALL assert the cycle after the IDLE->GRANT decision and SHALL never have more than one bit set.
REQ-018 On entry to GRANT, quota_left SHALL load QUOTA; it SHALL decrement once per granted cycle, so the maximum tenure is exactly QUOTA cycles.
REQ-019 While the window is closed, grant SHALL be 0; a tenure cut by window close SHALL drop grant on the first cycle window reads low.
REQ-020 The round-robin pointer SHALL persist across frames; a tenure cut at window close SHALL still count as that requester's turn.
REQ-021 If only one requester asserts req, it SHALL be re-granted after each HANDOVER cycle.
REQ-022 A req bit deasserting in the same cycle that its quota expires SHALL take a single HANDOVER, not two.
REQ-023 The owner output SHALL update only on grant assertion.

Reset
REQ-024 While rst_n is low at a clock edge, the following SHALL hold: state IDLE, grant 0, owner NREQ-1 (so requester 0 is first), quota_left 0, window 0.
REQ-025 Reset asserted mid-tenure SHALL drop grant on the next edge, with no HANDOVER cycle.

Configuration
REQ-026 Macro VBLANK_ARB_WINDOW_EN:
- Defined: arbitration is gated by the window as specified above.
- Undefined: window is tied to 1 and grants are issued in any line; all other rules are unchanged.

Structure
REQ-027 Shared package vga_pkg SHALL hold the FSM state typedef and the constants VBLANK_LINE, VTOTAL and the horizontal total.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module rr_pick (inputs req and last; output idx and valid).

Verification
REQ-029 With svpos=100 and req=3'b111 for a whole line, grant SHALL stay 0.
REQ-030 With svpos stepped to 480 and req=3'b111 held:
- grant sequence SHALL be 001 for 144 cycles, 000 for 1 cycle, 010 for 144 cycles, 000 for 1 cycle, then 100.
- quota_left SHALL count 144 down to 1 within each tenure.
REQ-031 With req=3'b010 only during the window, grant SHALL show 144 cycles of 010, then 1 cycle of 0, repeating.
REQ-032 If requester 0 drops req after 10 granted cycles:
- HANDOVER SHALL follow on the next cycle;
- requester 1 SHALL be granted with quota_left=144.
REQ-033 If svpos wraps from 524 to 0 mid-tenure, grant SHALL drop; in the next frame at line 480 the next requester in order SHALL be granted first.
REQ-034 If rst_n is pulled low for 1 cycle mid-tenure:
- grant SHALL drop to 0 on that edge;
- after release, requester 0 SHALL be granted first.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and arbiter state type for the video RAM port arbiter.
package vga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_HANDOVER = 2'd2
   } arb_state_e;

   localparam int VBLANK_LINE = 480;
   localparam int VTOTAL      = 525;
   localparam int HTOTAL      = 800;

   // True when line lies in [first, total).
   function automatic logic in_window(input logic [9:0] line, input int first, input int total);
      int v;
      v = {22'd0, line};
      return (v >= first) && (v < total);
   endfunction

endpackage

// File: rtl/vblank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, wrapping.
module rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   output logic [1:0]      idx,
   output logic            valid
);

   logic [1:0] pos_s;

   // Walk the requesters once starting after last; the earliest hit is kept.
   always_comb begin
      idx   = last;
      valid = 1'b0;
      pos_s = 2'd0;
      for (int k = 1; k <= NREQ; k++) begin
         pos_s = 2'((int'(last) + k) % NREQ);
         idx   = (!valid && req[pos_s]) ? pos_s : idx;
         valid = valid | req[pos_s];
      end
   end

endmodule

// File: rtl/vblank_arbiter.sv
// Video RAM port arbiter granting quota-limited tenures during vertical blank.
// Define VBLANK_ARB_WINDOW_EN to gate arbitration by the vblank window; otherwise the window is always open.
module vblank_arbiter #(
   parameter int NREQ        = 3,
   parameter int QUOTA       = 144,
   parameter int VBLANK_LINE = vga_pkg::VBLANK_LINE,
   parameter int VTOTAL      = vga_pkg::VTOTAL
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [9:0]      shpos,
   input  logic [9:0]      svpos,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      owner,
   output logic            window,
   output logic [7:0]      quota_left
);

   import vga_pkg::*;

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [1:0]      owner_q, owner_d;
   logic [7:0]      quota_q, quota_d;
   logic            window_q, window_d;

   logic [1:0]      pick_idx_s;
   logic            pick_valid_s;
   logic            pick_ok_s;
   logic            owner_req_s;
   logic            unused_inputs_s;

`ifdef VBLANK_ARB_WINDOW_EN
   assign window_d        = in_window(svpos, VBLANK_LINE, VTOTAL);
   assign unused_inputs_s = ^shpos;
`else
   assign window_d        = 1'b1;
   assign unused_inputs_s = ^{shpos, svpos};
`endif

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .last  (owner_q),
      .idx   (pick_idx_s),
      .valid (pick_valid_s)
   );

   // A new tenure may only start if the window is open now and stays open next cycle.
   assign pick_ok_s   = window_q && window_d && pick_valid_s;
   assign owner_req_s = req[owner_q];

   // Next-state logic; the dead HANDOVER cycle also evaluates the IDLE pick so only one idle grant cycle appears.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      quota_d = quota_q;
      case (state_q)
         ST_IDLE, ST_HANDOVER: begin
            if (pick_ok_s) begin
               state_d = ST_GRANT;
               grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
               owner_d = pick_idx_s;
               quota_d = 8'(QUOTA);
            end else begin
               state_d = ST_IDLE;
               grant_d = {NREQ{1'b0}};
               quota_d = 8'd0;
            end
         end
         ST_GRANT: begin
            if (!owner_req_s || (quota_q == 8'd1) || !window_d) begin
               state_d = ST_HANDOVER;
               grant_d = {NREQ{1'b0}};
               quota_d = 8'd0;
            end else begin
               quota_d = quota_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = {NREQ{1'b0}};
            quota_d = 8'd0;
         end
      endcase
   end

   // State and output registers; reset makes requester 0 first in line.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= {NREQ{1'b0}};
         owner_q  <= 2'(NREQ - 1);
         quota_q  <= 8'd0;
         window_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         quota_q  <= quota_d;
         window_q <= window_d;
      end
   end

   assign grant      = grant_q;
   assign owner      = owner_q;
   assign window     = window_q;
   assign quota_left = quota_q;

endmodule

// File: tb/tb_vblank_arbiter.sv
// Self-checking bench for vblank_arbiter: window table, directed corner sequences, randomized run vs. a reference model.
module tb_vblank_arbiter;

   localparam int NREQ  = 3;
   localparam int QUOTA = 144;
`ifdef VBLANK_ARB_WINDOW_EN
   localparam bit WIN_EN = 1'b1;
`else
   localparam bit WIN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] shpos;
   logic [9:0] svpos;
   logic [2:0] req;
   logic [2:0] grant;
   logic [1:0] owner;
   logic       window;
   logic [7:0] quota_left;

   int total = 0;
   int bad   = 0;

   // Reference model: current holder (-1 = none), last holder, remaining quota, window flag.
   int m_gi    = -1;
   int m_cur   = NREQ - 1;
   int m_quota = 0;
   bit m_win   = 1'b0;

   typedef struct {
      logic [9:0] sv;
      logic       exp_win;
   } win_vec_t;

   win_vec_t tbl[9];

   vblank_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .shpos      (shpos),
      .svpos      (svpos),
      .req        (req),
      .grant      (grant),
      .owner      (owner),
      .window     (window),
      .quota_left (quota_left)
   );

   always #5 clk = ~clk;

   function automatic bit win_rule(input logic [9:0] sv);
      int v;
      v = {22'd0, sv};
      if (!WIN_EN) return 1'b1;
      return (v >= 480) && (v < 525);
   endfunction

   function automatic logic ew(input logic lit);
      return WIN_EN ? lit : 1'b1;
   endfunction

   task automatic model_update(input logic rstn, input logic [9:0] sv, input logic [2:0] rq);
      bit wn;
      int c;
      wn = win_rule(sv);
      if (!rstn) begin
         m_gi = -1; m_cur = NREQ - 1; m_quota = 0; m_win = 1'b0;
         return;
      end
      if (m_gi >= 0) begin
         if (!rq[m_gi] || m_quota == 1 || !wn) begin
            m_gi = -1; m_quota = 0;
         end else begin
            m_quota = m_quota - 1;
         end
      end else if (m_win && wn && rq != 3'b000) begin
         for (int k = 1; k <= NREQ; k++) begin
            c = (m_cur + k) % NREQ;
            if (m_gi < 0 && rq[c]) m_gi = c;
         end
         m_cur = m_gi; m_quota = QUOTA;
      end
      m_win = wn;
   endtask

   task automatic step();
      logic [2:0] eg;
      @(posedge clk);
      model_update(rst_n, svpos, req);
      #1;
      eg = (m_gi < 0) ? 3'b000 : 3'(1 << m_gi);
      total++;
      if (grant !== eg || owner !== 2'(m_cur) || quota_left !== 8'(m_quota) || window !== m_win) begin
         bad++;
         $display("FAIL model @%0t grant=%b want %b owner=%0d want %0d quota=%0d want %0d window=%b want %b",
                  $time, grant, eg, owner, m_cur, quota_left, m_quota, window, m_win);
      end
      total++;
      if (!$onehot0(grant)) begin
         bad++;
         $display("FAIL onehot @%0t actual=%b required=at most one bit", $time, grant);
      end
      shpos = (shpos == 10'd799) ? 10'd0 : shpos + 10'd1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input string name, input int bound);
      int n;
      n = 0;
      while (grant === 3'b000 && n < bound) begin
         step();
         n++;
      end
      check({name, "_wait"}, int'(grant !== 3'b000), 1);
   endtask

   // Counts consecutive samples equal to g; granted runs must also count quota down from QUOTA.
   task automatic run_len(input logic [2:0] g, input int len, input string name);
      int n;
      bit qok;
      n = 0;
      qok = 1'b1;
      while (grant === g && n < len + 4) begin
         if (g != 3'b000 && int'(quota_left) != QUOTA - n) qok = 1'b0;
         n++;
         step();
      end
      check({name, "_len"}, n, len);
      if (g != 3'b000) check({name, "_quota"}, int'(qok), 1);
   endtask

   initial begin
      int cnt;
      int r;
      int hold;
      rst_n = 1'b0; shpos = 10'd0; svpos = 10'd0; req = 3'b000;

      tbl[0] = '{10'd0,    ew(1'b0)};
      tbl[1] = '{10'd479,  ew(1'b0)};
      tbl[2] = '{10'd480,  ew(1'b1)};
      tbl[3] = '{10'd481,  ew(1'b1)};
      tbl[4] = '{10'd524,  ew(1'b1)};
      tbl[5] = '{10'd100,  ew(1'b0)};
      tbl[6] = '{10'd525,  ew(1'b0)};
      tbl[7] = '{10'd1023, ew(1'b0)};
      tbl[8] = '{10'd500,  ew(1'b1)};

      // Reset values
      do_reset();
      check("rst_grant", int'(grant), 0);
      check("rst_owner", int'(owner), 2);
      check("rst_quota", int'(quota_left), 0);
      check("rst_window", int'(window), 0);

      // Window decode table, one cycle of lag
      for (int i = 0; i < 9; i++) begin
         svpos = tbl[i].sv;
         step();
         check("win_tbl", int'(window), int'(tbl[i].exp_win));
      end

      // Active line outside vblank
      do_reset();
      svpos = 10'd100; req = 3'b111;
`ifdef VBLANK_ARB_WINDOW_EN
      cnt = 0;
      for (int i = 0; i < 800; i++) begin
         step();
         if (grant !== 3'b000) cnt++;
      end
      check("line100_grants", cnt, 0);
`else
      wait_grant("line100_open", 5);
      check("line100_window", int'(window), 1);
`endif

      // Three requesters in vblank: round-robin with full quotas
      do_reset();
      svpos = 10'd480; req = 3'b111;
      wait_grant("rr", 5);
      run_len(3'b001, 144, "rr_t0");
      run_len(3'b000, 1, "rr_gap0");
      run_len(3'b010, 144, "rr_t1");
      run_len(3'b000, 1, "rr_gap1");
      check("rr_third", int'(grant), 4);
      check("rr_third_quota", int'(quota_left), 144);

      // Single requester is re-granted after each dead cycle
      req = 3'b010;
      step();
      check("solo_drop", int'(grant), 0);
      wait_grant("solo", 3);
      run_len(3'b010, 144, "solo_t0");
      run_len(3'b000, 1, "solo_gap0");
      run_len(3'b010, 144, "solo_t1");
      run_len(3'b000, 1, "solo_gap1");
      check("solo_again", int'(grant), 2);

      // Owner drops request after 10 granted cycles
      do_reset();
      svpos = 10'd480; req = 3'b111;
      wait_grant("drop", 5);
      check("drop_first", int'(grant), 1);
      for (int i = 0; i < 9; i++) step();
      req = 3'b110;
      step();
      check("drop_handover", int'(grant), 0);
      step();
      check("drop_next", int'(grant), 2);
      check("drop_next_quota", int'(quota_left), 144);

      // Frame wrap mid-tenure
      do_reset();
      svpos = 10'd524; req = 3'b111;
      wait_grant("wrap", 5);
      for (int i = 0; i < 5; i++) step();
      svpos = 10'd0;
      step();
`ifdef VBLANK_ARB_WINDOW_EN
      check("wrap_cut", int'(grant), 0);
      check("wrap_window", int'(window), 0);
      for (int i = 0; i < 3; i++) step();
      svpos = 10'd479;
      step();
      step();
      check("wrap_closed", int'(grant), 0);
      svpos = 10'd480;
      wait_grant("wrap_next", 5);
      check("wrap_next_owner", int'(grant), 2);
`else
      check("wrap_keep", int'(grant), 1);
`endif

      // Reset pulse mid-tenure
      do_reset();
      svpos = 10'd480; req = 3'b111;
      wait_grant("rstmid", 5);
      run_len(3'b001, 144, "rstmid_t0");
      run_len(3'b000, 1, "rstmid_gap");
      for (int i = 0; i < 20; i++) step();
      rst_n = 1'b0;
      step();
      check("rstmid_grant", int'(grant), 0);
      check("rstmid_owner", int'(owner), 2);
      rst_n = 1'b1;
      wait_grant("rstmid_after", 5);
      check("rstmid_first", int'(grant), 1);

      // Request drops on the last quota cycle: a single dead cycle
      for (int i = 0; i < 143; i++) step();
      check("lastq_quota", int'(quota_left), 1);
      req = 3'b110;
      step();
      check("lastq_dead", int'(grant), 0);
      step();
      check("lastq_next", int'(grant), 2);

      // Randomized raster positions, requests and rare resets against the model
      for (int chunk = 0; chunk < 60; chunk++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: svpos = 10'(470 + $urandom_range(0, 20));
            1: svpos = 10'(515 + $urandom_range(0, 15));
            2: svpos = 10'($urandom_range(0, 1023));
            default: svpos = 10'(480 + $urandom_range(0, 44));
         endcase
         hold = $urandom_range(1, 400);
         for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 19) == 0) req = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 499) != 0);
            step();
         end
      end
      rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
